// File: rtl/video_acc_sched.sv
// rtl/video_acc_sched.sv - instruction-driven scheduler for a video accelerator data path
//
// Decodes 32-bit instruction words, maintains read/write base address
// registers, issues paired mover requests (to-local read, from-local write),
// selects the stream router destination, and waits for the end-of-frame beat
// on the output buffer stream before accepting the next instruction.
//
// Optional feature macro: VIDEO_ACC_PERF_CNT_EN (busy-cycle performance counter).
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   inst_valid/ready/data   instruction word handshake
//   rd_addr/rd_len          to-local mover source address and byte length
//   rd_valid/rd_ready       to-local mover request handshake
//   wr_addr                 from-local mover destination address
//   wr_valid/wr_ready       from-local mover request handshake
//   route_dest              router destination (0 bypass, 1 DCT, 2 IDCT)
//   out_t_valid/ready/last  output-buffer stream monitor (observed only)
//   busy                    high whenever the scheduler is not idle
//   err                     sticky illegal-opcode flag
//   busy_cycles             busy-cycle counter (constant 0 when disabled)

module video_acc_sched #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEST_WIDTH = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [31:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] rd_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DEST_WIDTH-1:0] route_dest,
    input  logic                  out_t_valid,
    input  logic                  out_t_ready,
    input  logic                  out_t_last,
    output logic                  busy,
    output logic                  err,
    output logic [31:0]           busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    localparam logic [5:0] OP_NOP       = 6'd0;
    localparam logic [5:0] OP_MOV       = 6'd1;
    localparam logic [5:0] OP_LOAD_FULL = 6'd2;
    localparam logic [5:0] OP_LOAD_LOW  = 6'd3;
    localparam logic [5:0] OP_DCT       = 6'd4;
    localparam logic [5:0] OP_IDCT      = 6'd5;

    localparam logic [63:0] MASK_LOW21 = 64'h0000_0000_07FF_FFC0;
    localparam logic [63:0] MASK_LO32  = 64'h0000_0000_FFFF_FFC0;
    localparam logic [63:0] MASK_HI32  = 64'hFFFF_FFFF_0000_0000;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_base_rd;
    logic [ADDR_WIDTH-1:0]   r_base_wr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_rd_len;
    logic                    r_rd_valid;
    logic                    r_wr_valid;
    logic [DEST_WIDTH-1:0]   r_route_dest;
    logic                    r_err;
    logic [4:0]              r_load_attrib;

    logic [5:0]              w_opcode;
    logic [4:0]              w_attrib;
    logic [ADDR_WIDTH-1:0]   w_src;
    logic [ADDR_WIDTH-1:0]   w_dest;
    logic [ADDR_WIDTH-1:0]   w_len;
    logic                    w_len_zero;
    logic                    w_rd_ok;
    logic                    w_wr_ok;
    logic                    w_done_beat;

    assign w_opcode    = inst_data[5:0];
    assign w_attrib    = inst_data[31:27];
    assign w_src       = ADDR_WIDTH'({inst_data[12:6], 6'b0});
    assign w_dest      = ADDR_WIDTH'({inst_data[19:13], 6'b0});
    assign w_len       = ADDR_WIDTH'({inst_data[26:20], 6'b0});
    assign w_len_zero  = (inst_data[26:20] == 7'd0);

    // A request side is finished once it has handshaken: its valid is only
    // ever cleared by its own handshake while in ISSUE.
    assign w_rd_ok     = !r_rd_valid || rd_ready;
    assign w_wr_ok     = !r_wr_valid || wr_ready;
    assign w_done_beat = out_t_valid && out_t_ready && out_t_last;

    // Replace the bits selected by mask with val, keep the rest of base.
    function automatic logic [ADDR_WIDTH-1:0] f_merge(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [63:0]           val,
        input logic [63:0]           mask
    );
        logic [ADDR_WIDTH-1:0] m;
        logic [ADDR_WIDTH-1:0] v;
        m = ADDR_WIDTH'(mask);
        v = ADDR_WIDTH'(val);
        return (base & ~m) | (v & m);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_base_rd     <= '0;
            r_base_wr     <= '0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_rd_len      <= '0;
            r_rd_valid    <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_route_dest  <= '0;
            r_err         <= 1'b0;
            r_load_attrib <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_valid) begin
                        case (w_opcode)
                            OP_NOP: ;
                            OP_LOAD_FULL: begin
                                r_load_attrib <= w_attrib;
                                r_state       <= S_LOAD_LO;
                            end
                            OP_LOAD_LOW: begin
                                if (w_attrib == 5'd0)
                                    r_base_rd <= f_merge(r_base_rd, {37'd0, inst_data[26:6], 6'd0}, MASK_LOW21);
                                else if (w_attrib == 5'd1)
                                    r_base_wr <= f_merge(r_base_wr, {37'd0, inst_data[26:6], 6'd0}, MASK_LOW21);
                            end
                            OP_MOV, OP_DCT, OP_IDCT: begin
                                // Zero-length transfers are consumed as no-ops.
                                if (!w_len_zero) begin
                                    r_rd_addr  <= r_base_rd + w_src;
                                    r_wr_addr  <= r_base_wr + w_dest;
                                    r_rd_len   <= w_len;
                                    r_rd_valid <= 1'b1;
                                    r_wr_valid <= 1'b1;
                                    if (w_opcode == OP_DCT)
                                        r_route_dest <= DEST_WIDTH'(1);
                                    else if (w_opcode == OP_IDCT)
                                        r_route_dest <= DEST_WIDTH'(2);
                                    else
                                        r_route_dest <= DEST_WIDTH'(0);
                                    r_state    <= S_ISSUE;
                                end
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_LOAD_LO: begin
                    if (inst_valid) begin
                        if (r_load_attrib == 5'd0)
                            r_base_rd <= f_merge(r_base_rd, {32'd0, inst_data[31:6], 6'd0}, MASK_LO32);
                        else if (r_load_attrib == 5'd1)
                            r_base_wr <= f_merge(r_base_wr, {32'd0, inst_data[31:6], 6'd0}, MASK_LO32);
                        r_state <= S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    if (inst_valid) begin
                        if (r_load_attrib == 5'd0)
                            r_base_rd <= f_merge(r_base_rd, {inst_data, 32'd0}, MASK_HI32);
                        else if (r_load_attrib == 5'd1)
                            r_base_wr <= f_merge(r_base_wr, {inst_data, 32'd0}, MASK_HI32);
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (r_rd_valid && rd_ready) r_rd_valid <= 1'b0;
                    if (r_wr_valid && wr_ready) r_wr_valid <= 1'b0;
                    if (w_rd_ok && w_wr_ok)     r_state    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (w_done_beat) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_ready = (r_state == S_IDLE) || (r_state == S_LOAD_LO) || (r_state == S_LOAD_HI);
    assign busy       = (r_state != S_IDLE);
    assign rd_addr    = r_rd_addr;
    assign wr_addr    = r_wr_addr;
    assign rd_len     = r_rd_len;
    assign rd_valid   = r_rd_valid;
    assign wr_valid   = r_wr_valid;
    assign route_dest = r_route_dest;
    assign err        = r_err;

`ifdef VIDEO_ACC_PERF_CNT_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_busy_cycles <= '0;
        else if ((r_state != S_IDLE) && (r_busy_cycles != 32'hFFFF_FFFF))
            r_busy_cycles <= r_busy_cycles + 32'd1;
    end

    assign busy_cycles = r_busy_cycles;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_video_acc_sched.sv
// tb/tb_video_acc_sched.sv - directed self-checking bench for video_acc_sched

module tb_video_acc_sched;

    logic        aclk;
    logic        aresetn;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] rd_addr;
    logic [63:0] rd_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] wr_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  route_dest;
    logic        out_t_valid;
    logic        out_t_ready;
    logic        out_t_last;
    logic        busy;
    logic        err;
    logic [31:0] busy_cycles;

    int n_checks;
    int n_errors;

    video_acc_sched #(.ADDR_WIDTH(64), .DEST_WIDTH(3)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .route_dest(route_dest),
        .out_t_valid(out_t_valid), .out_t_ready(out_t_ready), .out_t_last(out_t_last),
        .busy(busy), .err(err), .busy_cycles(busy_cycles)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] enc(input int op, input int src, input int dst, input int len, input int at);
        logic [31:0] o, s, d, l, a;
        o = op; s = src; d = dst; l = len; a = at;
        return {a[4:0], l[12:6], d[12:6], s[12:6], o[5:0]};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        inst_valid = 1'b1;
        inst_data  = w;
        step();
        inst_valid = 1'b0;
        inst_data  = 32'd0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #3;
        aresetn = 1'b1;
        #1;
    endtask

    task automatic beat_done();
        out_t_valid = 1'b1; out_t_ready = 1'b1; out_t_last = 1'b1;
        step();
        out_t_valid = 1'b0; out_t_ready = 1'b0; out_t_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (inst_ready !== 1'b1) begin n_errors++; $display("FAIL reset_inst_ready: got %0h expected 1", inst_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0h expected 0", err); end
        n_checks++; if (rd_valid !== 1'b0 || wr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valids: got %0h/%0h expected 0/0", rd_valid, wr_valid); end
        n_checks++; if (rd_addr !== 64'd0 || wr_addr !== 64'd0 || rd_len !== 64'd0) begin n_errors++; $display("FAIL reset_addrs: got %0h/%0h/%0h expected 0", rd_addr, wr_addr, rd_len); end
        n_checks++; if (route_dest !== 3'd0 || busy_cycles !== 32'd0) begin n_errors++; $display("FAIL reset_route_cnt: got %0h/%0h expected 0/0", route_dest, busy_cycles); end
    endtask

    task automatic test_load_full();
        send(enc(2, 0, 0, 0, 0));
        n_checks++; if (busy !== 1'b1 || inst_ready !== 1'b1) begin n_errors++; $display("FAIL lf_load_lo: got busy=%0h rdy=%0h expected 1/1", busy, inst_ready); end
        send(32'h1234_5678);
        n_checks++; if (busy !== 1'b1 || inst_ready !== 1'b1) begin n_errors++; $display("FAIL lf_load_hi: got busy=%0h rdy=%0h expected 1/1", busy, inst_ready); end
        send(32'h0000_0001);
        n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL lf_idle: got busy=%0h err=%0h expected 0/0", busy, err); end
        rd_ready = 1'b1; wr_ready = 1'b1;
        send(enc(1, 0, 0, 'h40, 0));
        n_checks++; if (rd_addr !== 64'h0000_0001_1234_5640) begin n_errors++; $display("FAIL lf_base_rd: got %0h expected 112345640", rd_addr); end
        n_checks++; if (wr_addr !== 64'd0 || rd_len !== 64'h40) begin n_errors++; $display("FAIL lf_wr_len: got %0h/%0h expected 0/40", wr_addr, rd_len); end
        step();
        n_checks++; if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL lf_wait: got %0h/%0h/%0h expected 0/0/1", rd_valid, wr_valid, busy); end
        beat_done();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL lf_done: got %0h expected 0", busy); end
    endtask

    task automatic test_mov();
        rd_ready = 1'b0; wr_ready = 1'b0;
        send(enc(2, 0, 0, 0, 0)); send(32'h0000_1000); send(32'h0);
        send(enc(2, 0, 0, 0, 1)); send(32'h0000_2000); send(32'h0);
        send(enc(1, 'h40, 'h80, 'h100, 0));
        n_checks++; if (rd_valid !== 1'b1 || wr_valid !== 1'b1) begin n_errors++; $display("FAIL mov_valids: got %0h/%0h expected 1/1", rd_valid, wr_valid); end
        n_checks++; if (rd_addr !== 64'h1040 || wr_addr !== 64'h2080) begin n_errors++; $display("FAIL mov_addrs: got %0h/%0h expected 1040/2080", rd_addr, wr_addr); end
        n_checks++; if (rd_len !== 64'h100 || route_dest !== 3'd0) begin n_errors++; $display("FAIL mov_len_dest: got %0h/%0h expected 100/0", rd_len, route_dest); end
        n_checks++; if (inst_ready !== 1'b0) begin n_errors++; $display("FAIL mov_inst_ready: got %0h expected 0", inst_ready); end
        step(); step();
        n_checks++; if (rd_valid !== 1'b1 || wr_valid !== 1'b1 || rd_addr !== 64'h1040) begin n_errors++; $display("FAIL mov_hold: got %0h/%0h/%0h expected 1/1/1040", rd_valid, wr_valid, rd_addr); end
        rd_ready = 1'b1; wr_ready = 1'b1;
        step();
        rd_ready = 1'b0; wr_ready = 1'b0;
        n_checks++; if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL mov_hs: got %0h/%0h/%0h expected 0/0/1", rd_valid, wr_valid, busy); end
        beat_done();
        n_checks++; if (inst_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL mov_done: got %0h/%0h expected 1/0", inst_ready, busy); end
    endtask

    task automatic test_load_low();
        send(32'h0000_3003);
        send(32'h1555_5543);
        send(32'h0000_0000);
        n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL ll_nop: got %0h/%0h expected 0/0", busy, err); end
        send(enc(1, 'h40, 'h40, 0, 0));
        n_checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_addr !== 64'h1040) begin n_errors++; $display("FAIL ll_len0: got %0h/%0h/%0h expected 0/0/1040", busy, rd_valid, rd_addr); end
        rd_ready = 1'b1; wr_ready = 1'b1;
        send(enc(1, 0, 0, 'h40, 0));
        n_checks++; if (rd_addr !== 64'h3000 || wr_addr !== 64'h2000) begin n_errors++; $display("FAIL ll_base: got %0h/%0h expected 3000/2000", rd_addr, wr_addr); end
        step();
        beat_done();
    endtask

    task automatic test_dct_backpressure();
        rd_ready = 1'b0; wr_ready = 1'b1;
        send(enc(4, 'h40, 0, 'h80, 0));
        n_checks++; if (rd_addr !== 64'h3040 || rd_len !== 64'h80 || route_dest !== 3'd1) begin n_errors++; $display("FAIL dct_issue: got %0h/%0h/%0h expected 3040/80/1", rd_addr, rd_len, route_dest); end
        step();
        n_checks++; if (wr_valid !== 1'b0 || rd_valid !== 1'b1) begin n_errors++; $display("FAIL dct_wr_drop: got wr=%0h rd=%0h expected 0/1", wr_valid, rd_valid); end
        out_t_valid = 1'b1; out_t_ready = 1'b1; out_t_last = 1'b1;
        step();
        out_t_valid = 1'b0; out_t_ready = 1'b0; out_t_last = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL dct_beat_ignored: got %0h/%0h expected 1/1", rd_valid, busy); end
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL dct_rd_drop: got %0h/%0h expected 0/1", rd_valid, busy); end
        step();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL dct_wait_hold: got %0h expected 1", busy); end
        beat_done();
        n_checks++; if (busy !== 1'b0 || route_dest !== 3'd1) begin n_errors++; $display("FAIL dct_done: got %0h/%0h expected 0/1", busy, route_dest); end
    endtask

    task automatic test_idct_wait_done();
        rd_ready = 1'b1; wr_ready = 1'b1;
        send(enc(5, 0, 'h40, 'h40, 0));
        n_checks++; if (route_dest !== 3'd2 || wr_addr !== 64'h2040) begin n_errors++; $display("FAIL idct_issue: got %0h/%0h expected 2/2040", route_dest, wr_addr); end
        step();
        out_t_valid = 1'b1; out_t_last = 1'b1; out_t_ready = 1'b0;
        step();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL idct_not_ready: got %0h expected 1", busy); end
        out_t_ready = 1'b1; out_t_last = 1'b0;
        step();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL idct_not_last: got %0h expected 1", busy); end
        out_t_last = 1'b1;
        step();
        out_t_valid = 1'b0; out_t_ready = 1'b0; out_t_last = 1'b0;
        n_checks++; if (busy !== 1'b0 || inst_ready !== 1'b1 || route_dest !== 3'd2) begin n_errors++; $display("FAIL idct_done: got %0h/%0h/%0h expected 0/1/2", busy, inst_ready, route_dest); end
    endtask

    task automatic test_illegal();
        send(32'h0000_003F);
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || inst_ready !== 1'b1) begin n_errors++; $display("FAIL ill_flag: got %0h/%0h/%0h expected 1/0/1", err, busy, inst_ready); end
        rd_ready = 1'b1; wr_ready = 1'b1;
        send(enc(1, 0, 0, 'h40, 0));
        n_checks++; if (rd_valid !== 1'b1 || route_dest !== 3'd0 || err !== 1'b1) begin n_errors++; $display("FAIL ill_next_mov: got %0h/%0h/%0h expected 1/0/1", rd_valid, route_dest, err); end
        step();
        beat_done();
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ill_reset: got %0h expected 0", err); end
    endtask

    task automatic test_reset_mid_transfer();
        rd_ready = 1'b0; wr_ready = 1'b0;
        send(enc(1, 'h40, 'h80, 'h40, 0));
        n_checks++; if (rd_valid !== 1'b1 || rd_addr !== 64'h40) begin n_errors++; $display("FAIL rmt_issue: got %0h/%0h expected 1/40", rd_valid, rd_addr); end
        do_reset();
        n_checks++; if (rd_valid !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== 64'd0) begin n_errors++; $display("FAIL rmt_reset: got %0h/%0h/%0h/%0h expected 0/0/0/0", rd_valid, wr_valid, busy, rd_addr); end
        step();
        n_checks++; if (rd_valid !== 1'b0 || inst_ready !== 1'b1) begin n_errors++; $display("FAIL rmt_after: got %0h/%0h expected 0/1", rd_valid, inst_ready); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
`ifdef VIDEO_ACC_PERF_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        rd_ready = 1'b1; wr_ready = 1'b1;
        send(enc(1, 0, 0, 'h40, 0));
        n_checks++; if (busy_cycles !== 32'd0) begin n_errors++; $display("FAIL perf_start: got %0d expected 0", busy_cycles); end
        step();
        for (int i = 0; i < 8; i++) step();
        beat_done();
        n_checks++; if (busy !== 1'b0 || busy_cycles !== exp_cnt) begin n_errors++; $display("FAIL perf_count: got busy=%0h cnt=%0d expected 0/%0d", busy, busy_cycles, exp_cnt); end
        step(); step();
        n_checks++; if (busy_cycles !== exp_cnt) begin n_errors++; $display("FAIL perf_hold: got %0d expected %0d", busy_cycles, exp_cnt); end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        aresetn     = 1'b0;
        inst_valid  = 1'b0;
        inst_data   = 32'd0;
        rd_ready    = 1'b0;
        wr_ready    = 1'b0;
        out_t_valid = 1'b0;
        out_t_ready = 1'b0;
        out_t_last  = 1'b0;
        #2;
        test_reset();
        test_load_full();
        test_mov();
        test_load_low();
        test_dct_backpressure();
        test_idct_wait_done();
        test_illegal();
        test_reset_mid_transfer();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
